// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM SRAM port arbiter.
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, DONE} arb_state_t;

  typedef enum logic {GNT_IF, GNT_MEM} grant_t;

  localparam int unsigned DefaultWaitCycles = 4;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cntWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Clear-able up-counter; tc flags the last wait cycle of an SRAM access.
module sram_wait_counter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DefaultWaitCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = cntWidth(WAIT_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(WAIT_CYCLES - 1);

  logic [CntW-1:0] cntQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntQ <= '0;
    end else if (clr) begin
      cntQ <= '0;
    end else if (en) begin
      cntQ <= cntQ + 1'b1;
    end
  end

  assign tc = (cntQ == LastCnt);

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates the single-ported SRAM between the fetch and memory stages and
// produces the pipeline freeze signals.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = DefaultWaitCycles
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              freeze_if,
  output logic              freeze_mem,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  arb_state_t        stateQ, stateD;
  grant_t            lastGntQ, lastGntD;
  logic              discardQ, discardD;
  logic              sramEnQ, sramEnD;
  logic              sramWeQ, sramWeD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic [DATA_W-1:0] wdataQ, wdataD;
  logic [DATA_W-1:0] ifRdataQ, ifRdataD;
  logic [DATA_W-1:0] memRdataQ, memRdataD;

  logic memReq, ifReq, grantMem, grantIf;
  logic cntClr, cntEn, cntTc;

  assign memReq = mem_rd_en | mem_wr_en;
  assign ifReq  = if_req & ~if_flush;
  assign cntEn  = (stateQ == IF_BUSY) || (stateQ == MEM_BUSY);

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) uWaitCounter (
    .clk(clk),
    .rst(rst),
    .clr(cntClr),
    .en (cntEn),
    .tc (cntTc)
  );

  always_comb begin
    stateD    = stateQ;
    lastGntD  = lastGntQ;
    discardD  = discardQ;
    sramEnD   = sramEnQ;
    sramWeD   = sramWeQ;
    addrD     = addrQ;
    wdataD    = wdataQ;
    ifRdataD  = ifRdataQ;
    memRdataD = memRdataQ;
    grantMem  = 1'b0;
    grantIf   = 1'b0;
    cntClr    = 1'b0;

    unique case (stateQ)
      IDLE: begin
        discardD = 1'b0;
        // On a tie the side that did not win last time is served.
        if (memReq && (!ifReq || lastGntQ == GNT_IF)) begin
          grantMem = 1'b1;
        end else if (ifReq) begin
          grantIf = 1'b1;
        end
        if (grantMem || grantIf) begin
          cntClr   = 1'b1;
          sramEnD  = 1'b1;
          sramWeD  = grantMem & mem_wr_en;
          addrD    = grantMem ? mem_addr : if_addr;
          wdataD   = grantMem ? mem_wdata : '0;
          lastGntD = grantMem ? GNT_MEM : GNT_IF;
          stateD   = grantMem ? MEM_BUSY : IF_BUSY;
        end
      end
      IF_BUSY: begin
        if (if_flush) begin
          discardD = 1'b1;
        end
        if (cntTc) begin
          if (!discardQ && !if_flush) begin
            ifRdataD = sram_rdata;
          end
          sramEnD = 1'b0;
          sramWeD = 1'b0;
          addrD   = '0;
          wdataD  = '0;
          stateD  = DONE;
        end
      end
      MEM_BUSY: begin
        if (cntTc) begin
          if (!sramWeQ) begin
            memRdataD = sram_rdata;
          end
          sramEnD = 1'b0;
          sramWeD = 1'b0;
          addrD   = '0;
          wdataD  = '0;
          stateD  = DONE;
        end
      end
      DONE: begin
        // No grant here: the requester has not yet dropped the request just served.
        discardD = 1'b0;
        stateD   = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ    <= IDLE;
      lastGntQ  <= GNT_IF;
      discardQ  <= 1'b0;
      sramEnQ   <= 1'b0;
      sramWeQ   <= 1'b0;
      addrQ     <= '0;
      wdataQ    <= '0;
      ifRdataQ  <= '0;
      memRdataQ <= '0;
    end else begin
      stateQ    <= stateD;
      lastGntQ  <= lastGntD;
      discardQ  <= discardD;
      sramEnQ   <= sramEnD;
      sramWeQ   <= sramWeD;
      addrQ     <= addrD;
      wdataQ    <= wdataD;
      ifRdataQ  <= ifRdataD;
      memRdataQ <= memRdataD;
    end
  end

  assign sram_en    = sramEnQ;
  assign sram_we    = sramWeQ;
  assign sram_addr  = addrQ;
  assign sram_wdata = wdataQ;
  assign if_rdata   = ifRdataQ;
  assign mem_rdata  = memRdataQ;

  assign if_valid  = (stateQ == DONE) && (lastGntQ == GNT_IF) && !discardQ && !if_flush;
  assign mem_ready = (stateQ == DONE) && (lastGntQ == GNT_MEM);

  // Gated by reset so every output reads 0 while reset is held.
  assign freeze_mem = ~rst & memReq & ~mem_ready;
  assign freeze_if  = ~rst & ((if_req & ~if_valid & ~if_flush) | freeze_mem);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a completion scoreboard.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, mem_rd_en, mem_wr_en;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata, sram_rdata;
  logic        if_valid, mem_ready, freeze_if, freeze_mem, sram_en, sram_we;

  typedef struct {
    logic        isIf;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .WAIT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_flush(if_flush),
    .if_rdata(if_rdata),
    .if_valid(if_valid),
    .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .freeze_if(freeze_if),
    .freeze_mem(freeze_mem),
    .sram_en(sram_en),
    .sram_we(sram_we),
    .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  // SRAM contents model: one fixed instruction, everything else address-derived.
  function automatic logic [31:0] modelWord(input logic [31:0] a);
    if (a == 32'h10) return 32'hE3A0_1005;
    return a ^ 32'h5A5A_0000;
  endfunction

  assign sram_rdata = sram_en ? modelWord(sram_addr) : 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic pushExp(input logic isIf, input logic [31:0] data, input int due);
    exp_t e;
    e.isIf = isIf;
    e.data = data;
    e.due  = due;
    sb.push_back(e);
  endtask

  task automatic doReset();
    rst = 1'b1;
    go();
    rst = 1'b0;
  endtask

  // Completion monitor: every pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (if_valid || mem_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_pulse", {30'b0, if_valid, mem_ready}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", {31'b0, if_valid}, {31'b0, e.isIf});
        chk("pulse_cycle", cyc, e.due);
        chk("pulse_data", e.isIf ? if_rdata : mem_rdata, e.data);
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      chk("missed_pulse", cyc, sb[0].due);
      void'(sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_flush = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;

    // Reset state
    samp();
    chk("rst_sram_en", sram_en, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_freeze", {freeze_if, freeze_mem}, 0);
    chk("rst_rdata", if_rdata | mem_rdata, 0);
    go();
    rst = 1'b0;

    // Lone fetch
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h10;
    pushExp(1'b1, 32'hE3A0_1005, t0 + 5);
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) if_req = 1'b0;
      samp();
      chk($sformatf("fetch_sram_en_c%0d", k), sram_en, (k >= 1 && k <= 4) ? 1 : 0);
      chk($sformatf("fetch_freeze_if_c%0d", k), freeze_if, (k <= 4) ? 1 : 0);
      if (k == 2) chk("fetch_sram_addr", sram_addr, 32'h10);
      go();
    end
    chk("fetch_rdata_held", if_rdata, 32'hE3A0_1005);

    // Tie after reset: MEM first, then IF
    doReset();
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h20; mem_rd_en = 1'b1; mem_addr = 32'h30;
    pushExp(1'b0, modelWord(32'h30), t0 + 5);
    pushExp(1'b1, modelWord(32'h20), t0 + 11);
    for (int k = 0; k <= 12; k++) begin
      if (k == 6) mem_rd_en = 1'b0;
      if (k == 12) if_req = 1'b0;
      samp();
      if (k == 0) chk("tie_freeze_mem", freeze_mem, 1);
      if (k == 1) chk("tie_first_addr", sram_addr, 32'h30);
      if (k == 6) chk("tie_idle_gap", sram_en, 0);
      if (k == 7) chk("tie_second_addr", sram_addr, 32'h20);
      go();
    end

    // Store
    t0 = cyc;
    mem_wr_en = 1'b1; mem_addr = 32'h400; mem_wdata = 32'h55;
    pushExp(1'b0, modelWord(32'h30), t0 + 5);
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) mem_wr_en = 1'b0;
      samp();
      if (k >= 1 && k <= 4) begin
        chk($sformatf("store_we_c%0d", k), sram_we, 1);
        chk($sformatf("store_addr_c%0d", k), sram_addr, 32'h400);
        chk($sformatf("store_wdata_c%0d", k), sram_wdata, 32'h55);
      end
      if (k == 5) chk("store_we_off", sram_we, 0);
      go();
    end

    // Flush during IF_BUSY: access completes, result discarded
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h40;
    for (int k = 0; k <= 7; k++) begin
      if (k == 2) if_flush = 1'b1;
      if (k == 3) begin if_flush = 1'b0; if_req = 1'b0; end
      samp();
      if (k == 2) chk("flush_freeze_if", freeze_if, 0);
      if (k == 4) chk("flush_access_runs", sram_en, 1);
      if (k == 5) chk("flush_no_valid", if_valid, 0);
      go();
    end
    chk("flush_rdata_kept", if_rdata, modelWord(32'h20));

    // Flush during DONE suppresses the pulse
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h50;
    for (int k = 0; k <= 6; k++) begin
      if (k == 5) if_flush = 1'b1;
      if (k == 6) begin if_flush = 1'b0; if_req = 1'b0; end
      samp();
      if (k == 5) chk("done_flush_no_valid", if_valid, 0);
      go();
    end

    // Reset mid MEM read
    mem_rd_en = 1'b1; mem_addr = 32'h60;
    for (int k = 0; k < 3; k++) go();
    rst = 1'b1;
    #1;
    chk("mid_rst_sram", {sram_en, sram_we}, 0);
    chk("mid_rst_sram_addr", sram_addr, 0);
    chk("mid_rst_freeze", {freeze_if, freeze_mem}, 0);
    chk("mid_rst_rdata", if_rdata | mem_rdata, 0);
    mem_rd_en = 1'b0;
    go();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      samp();
      chk($sformatf("post_rst_quiet_c%0d", k), {sram_en, mem_ready}, 0);
      go();
    end
    t0 = cyc;
    mem_rd_en = 1'b1; mem_addr = 32'h70;
    pushExp(1'b0, modelWord(32'h70), t0 + 5);
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) mem_rd_en = 1'b0;
      samp();
      go();
    end

    // Fairness: both sides held high continuously
    doReset();
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h80; mem_rd_en = 1'b1; mem_addr = 32'h90;
    pushExp(1'b0, modelWord(32'h90), t0 + 5);
    pushExp(1'b1, modelWord(32'h80), t0 + 11);
    pushExp(1'b0, modelWord(32'h90), t0 + 17);
    pushExp(1'b1, modelWord(32'h80), t0 + 23);
    for (int k = 0; k <= 26; k++) begin
      if (k == 24) begin if_req = 1'b0; mem_rd_en = 1'b0; end
      samp();
      if (k == 5) chk("fair_freeze_mem_done", freeze_mem, 0);
      if (k == 6) chk("fair_freeze_mem_idle", freeze_mem, 1);
      if (k == 13) chk("fair_third_addr", sram_addr, 32'h90);
      if (k == 25) chk("fair_quiet", sram_en, 0);
      go();
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
